// File: rtl/cnn_stream_pkg.sv
// Shared types and helpers for the CNN streaming pipeline stages.
package cnn_stream_pkg;

  localparam int unsigned T_DEFAULT = 8;

  // Widest sample the shared helpers support; callers sign-extend into it.
  localparam int unsigned SMAX_W = 32;

  typedef enum logic [1:0] {
    ACCUM,
    OUTPUT,
    DRAIN
  } pool_state_t;

  // Signed maximum. Both operands are sign-extended by the caller, so the result
  // is always one of them and truncating back to the caller's width is exact.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_1d_stream.sv
// Streaming 1-D max-pool: one signed maximum per non-overlapping window of P
// samples, floor(L/P) outputs per L-sample frame, trailing remainder discarded.
module maxpool_1d_stream
  import cnn_stream_pkg::*;
#(
  parameter int unsigned T = T_DEFAULT,
  parameter int unsigned P = 2,
  parameter int unsigned L = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int unsigned CW = $clog2(L + 1);
  localparam int unsigned WW = (P > 1) ? $clog2(P) : 1;

  localparam logic [CW-1:0] L_FULL    = CW'(L);
  localparam logic [CW-1:0] L_LAST    = CW'(L - 1);
  localparam logic [CW-1:0] LAST_FULL = CW'(L - P);
  localparam logic [WW-1:0] W_LAST    = WW'(P - 1);

  pool_state_t        state;
  logic [WW-1:0]      win_cnt;
  logic [CW-1:0]      in_cnt;
  logic signed [T-1:0] max_reg;
  logic signed [T-1:0] max_next;
  logic               accept;

  always_comb begin
    max_next = T'(smax(SMAX_W'(x_data), SMAX_W'(max_reg)));
  end

  // Outputs are functions of the registered state; reset masks them in its own cycle.
  always_comb begin
    x_ready = !reset && (state != OUTPUT);
    y_valid = !reset && (state == OUTPUT);
    y_data  = y_valid ? max_reg : '0;
    accept  = x_valid && x_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACCUM;
      win_cnt <= '0;
      in_cnt  <= '0;
      max_reg <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            in_cnt  <= in_cnt + 1'b1;
            max_reg <= (win_cnt == '0) ? x_data : max_next;
            if (win_cnt == W_LAST) begin
              win_cnt <= '0;
              state   <= OUTPUT;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (y_ready) begin
            if (in_cnt == L_FULL) begin
              in_cnt <= '0;
              state  <= ACCUM;
            end else if (in_cnt > LAST_FULL) begin
              // fewer than P samples left in the frame: swallow them
              state <= DRAIN;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            if (in_cnt == L_LAST) begin
              in_cnt  <= '0;
              win_cnt <= '0;
              state   <= ACCUM;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_1d_stream.sv
// Scoreboard bench for maxpool_1d_stream: instance A (L=13, P=2) and B (L=12, P=3).
module tb_maxpool_1d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic signed [7:0] ax_data, ay_data, bx_data, by_data;
  logic ax_valid, ax_ready, ay_valid, ay_ready;
  logic bx_valid, bx_ready, by_valid, by_ready;

  maxpool_1d_stream #(.T(8), .P(2), .L(13)) dut_a (
    .clk(clk), .reset(reset),
    .x_data(ax_data), .x_valid(ax_valid), .x_ready(ax_ready),
    .y_data(ay_data), .y_valid(ay_valid), .y_ready(ay_ready)
  );

  maxpool_1d_stream #(.T(8), .P(3), .L(12)) dut_b (
    .clk(clk), .reset(reset),
    .x_data(bx_data), .x_valid(bx_valid), .x_ready(bx_ready),
    .y_data(by_data), .y_valid(by_valid), .y_ready(by_ready)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic signed [7:0] qa[$];
  logic signed [7:0] qb[$];
  int a_vcnt = 0;
  int b_vcnt = 0;
  int a_acc = 0;
  int a_rmode = 0;   // 0: ready high, 1: ready low, 2: random

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected none", name);
  endtask

  // y_ready driver for instance A
  initial begin
    ay_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (a_rmode)
        0: ay_ready = 1'b1;
        1: ay_ready = 1'b0;
        default: ay_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!reset && ax_valid && ax_ready) a_acc = a_acc + 1;
    end
  end

  // Monitor A: pops expected values on output transfers, checks hold during stalls
  initial begin
    logic a_stall;
    logic signed [7:0] a_hold;
    a_stall = 1'b0;
    a_hold = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        a_stall = 1'b0;
      end else begin
        if (a_stall) begin
          chk("a_hold_valid", ay_valid, 1);
          chk("a_hold_data", ay_data, a_hold);
        end
        if (ay_valid) begin
          a_vcnt++;
          chk("a_xready_in_output", ax_ready, 0);
          if (ay_ready) begin
            if (qa.size() == 0) fail_now("a_unexpected_output");
            else chk("a_y_data", ay_data, qa.pop_front());
          end
        end
        a_stall = ay_valid && !ay_ready;
        a_hold = ay_data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && by_valid) begin
        b_vcnt++;
        chk("b_xready_in_output", bx_ready, 0);
        if (by_ready) begin
          if (qb.size() == 0) fail_now("b_unexpected_output");
          else chk("b_y_data", by_data, qb.pop_front());
        end
      end
    end
  end

  task automatic send_a(input logic signed [7:0] v, input int unsigned gap);
    ax_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    ax_data = v;
    ax_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ax_ready) begin
        @(posedge clk);
        #1;
        ax_valid = 1'b0;
        return;
      end
    end
    fail_now("a_send_timeout");
    ax_valid = 1'b0;
  endtask

  task automatic send_b(input logic signed [7:0] v);
    bx_data = v;
    bx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bx_ready) begin
        @(posedge clk);
        #1;
        bx_valid = 1'b0;
        return;
      end
    end
    fail_now("b_send_timeout");
    bx_valid = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 500 && qa.size() != 0; i++) @(negedge clk);
    if (qa.size() != 0) fail_now("a_drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    for (int i = 0; i < 500 && qb.size() != 0; i++) @(negedge clk);
    if (qb.size() != 0) fail_now("b_drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int v);
    qa.push_back(8'(v));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  int f1[13] = '{3, 7, -2, 0, 5, 5, -128, 127, 10, 9, 0, 1, 42};
  int e1[6]  = '{7, 0, 5, 127, 10, 1};
  int fb[12] = '{-5, -1, -9, 0, 0, 0, 2, 8, 8, -128, -127, -126};
  int eb[4]  = '{-1, 0, 8, -126};

  initial begin
    reset = 1'b1;
    ax_valid = 1'b0; ax_data = '0;
    bx_valid = 1'b0; bx_data = '0;
    by_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_yvalid", ay_valid, 0);
    chk("rst_a_xready", ax_ready, 0);
    chk("rst_a_ydata", ay_data, 0);
    chk("rst_b_xready", bx_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_a_xready", ax_ready, 1);
    chk("post_rst_a_yvalid", ay_valid, 0);
    chk("post_rst_a_ydata", ay_data, 0);
    chk("post_rst_b_xready", bx_ready, 1);
    @(posedge clk); #1;

    // Frame 1, unstalled: six outputs, 42 swallowed in DRAIN
    a_vcnt = 0;
    foreach (e1[i]) push_a(e1[i]);
    foreach (f1[i]) send_a(8'(f1[i]), 0);
    drain_a();
    chk("frame1_yvalid_cycles", a_vcnt, 6);

    // Frame 1 again with a 5-cycle stall on the first output (7)
    a_rmode = 1;
    foreach (e1[i]) push_a(e1[i]);
    fork
      begin
        foreach (f1[i]) send_a(8'(f1[i]), 0);
      end
      begin
        int w;
        int acc0;
        w = 0;
        @(negedge clk);
        while (!ay_valid && w < 100) begin
          @(negedge clk);
          w++;
        end
        if (!ay_valid) fail_now("stall_wait_valid");
        acc0 = a_acc;
        repeat (5) begin
          chk("stall_ydata", ay_data, 7);
          chk("stall_yvalid", ay_valid, 1);
          chk("stall_xready", ax_ready, 0);
          @(negedge clk);
        end
        chk("stall_no_accept", a_acc, acc0);
        a_rmode = 0;
      end
    join
    drain_a();

    // Back-to-back frames, then the first window of a third frame
    foreach (e1[i]) push_a(e1[i]);
    foreach (f1[i]) send_a(8'(f1[i]), 0);
    for (int v = 1; v <= 13; v++) begin
      if (v % 2 == 0) push_a(v);
      send_a(8'(v), 0);
    end
    push_a(20);
    send_a(8'(20), 0);
    send_a(-8'sd3, 0);
    drain_a();

    // Reset mid-window: 100 is lost
    send_a(8'(100), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_yvalid", ay_valid, 0);
    chk("midrst_xready", ax_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_release_xready", ax_ready, 1);
    @(posedge clk); #1;
    push_a(9);
    send_a(8'(4), 0);
    send_a(8'(9), 0);
    drain_a();

    // Instance B: L=12, P=3, exact fit, then a second frame straight after
    b_vcnt = 0;
    foreach (eb[i]) qb.push_back(8'(eb[i]));
    for (int v = 3; v <= 12; v += 3) qb.push_back(8'(v));
    foreach (fb[i]) send_b(8'(fb[i]));
    for (int v = 1; v <= 12; v++) send_b(8'(v));
    drain_b();
    chk("b_yvalid_cycles", b_vcnt, 8);

    // Random gaps and backpressure against a frame-position model
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    a_rmode = 2;
    begin
      int pos;
      logic signed [7:0] m;
      logic signed [7:0] v;
      pos = 0;
      m = '0;
      for (int n = 0; n < 2400; n++) begin
        v = 8'($urandom);
        if (pos < 12) begin
          if (pos % 2 == 0) m = v;
          else if (v > m) m = v;
          if (pos % 2 == 1) qa.push_back(m);
        end
        pos = (pos + 1) % 13;
        send_a(v, $urandom_range(0, 2));
      end
    end
    a_rmode = 0;
    drain_a();
    chk("random_queue_empty", qa.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_1d_stream.md
Name: maxpool_1d_stream

Overview:
- Streaming 1-D max-pool stage that sits directly downstream of the convolution stage.
- Consumes the convolution's post-ReLU y stream over a valid/ready handshake.
- Emits one signed maximum per non-overlapping window of P samples.
- Per frame of L input samples, emits floor(L/P) outputs; trailing L mod P samples are accepted and discarded. Frames run back-to-back.

Parameters:
- T, 8: sample width in bits, signed two's complement, same as the upstream stage.
- P, 2: window size and stride. Must be ≥1 and ≤L.
- L, 13: input samples per frame (upstream N-M+1).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- x_data  input  T  signed input sample
- x_valid  input  1  upstream sample valid
- x_ready  output  1  this block accepts x_data this cycle
- y_data  output  T  signed pooled maximum
- y_valid  output  1  y_data valid
- y_ready  input  1  downstream accepts y_data

Behaviour:
- Transfers: an input transfer occurs on x_valid && x_ready at a rising edge. An output transfer occurs on y_valid && y_ready.
- Counters:
  - win_cnt, range 0..P-1: position within the current window.
  - in_cnt, range 0..L: samples accepted in the current frame.
- States:
  - ACCUM: x_ready=1, y_valid=0.
  - OUTPUT: x_ready=0, y_valid=1.
  - DRAIN: x_ready=1, y_valid=0.
- ACCUM:
  - Each accepted sample: win_cnt==0 → max_reg<=x_data; else max_reg<=(x_data>max_reg ? x_data : max_reg). The comparison is full-width signed.
  - in_cnt++ on each accepted sample.
  - Accepting the sample with win_cnt==P-1 → win_cnt<=0, next state OUTPUT. Otherwise win_cnt++.
- OUTPUT:
  - y_data=max_reg.
  - y_data and y_valid hold stable until y_ready.
  - No input is accepted in this state.
  - On output transfer:
    - in_cnt==L → clear in_cnt, go to ACCUM (new frame).
    - L-in_cnt < P → go to DRAIN.
    - Otherwise → go to ACCUM.
- DRAIN:
  - Accepted samples increment in_cnt and are discarded; max_reg is unchanged.
  - Accepting the sample that makes in_cnt==L → clear in_cnt and win_cnt, go to ACCUM.
- Latency and throughput:
  - y_valid rises the cycle after the P-th sample of a window is accepted.
  - Unstalled throughput: one output per P+1 cycles.
- Reset:
  - Synchronous; takes priority over all other activity, including mid-window, mid-OUTPUT and mid-DRAIN.
  - On reset: state=ACCUM, win_cnt=0, in_cnt=0, max_reg=0.
  - Outputs during reset and after it: y_valid=0, y_data=0.
  - x_ready is forced to 0 in any cycle where reset=1. It goes to 1 the first cycle after reset deasserts.
  - A partial window in progress at reset is lost.
- Boundary cases:
  - P==1: each sample passes through with one cycle of latency and one bubble cycle.
  - L mod P==0: DRAIN is never entered.
  - x_valid held high while in OUTPUT: no transfer occurs, and the upstream holds x_data.
- Arithmetic: no width growth and no saturation; y_data is always one of the input samples.

Decomposition:
- Shared package cnn_stream_pkg:
  - default sample width constant T_DEFAULT=8;
  - state enum {ACCUM, OUTPUT, DRAIN};
  - function smax(a,b) for a signed T-bit maximum, reusable by later pooling stages.
- No sub-module: the counters, max register and 3-state FSM fit cleanly in one control/datapath module.

Test Plan:
- Frame 1 (L=13, P=2): x = 3,7,-2,0,5,5,-128,127,10,9,0,1,42 with y_ready=1.
  - Required y: 7,0,5,127,10,1.
  - 42 is accepted in DRAIN and never emitted.
  - y_valid is high exactly 6 cycles.
- Backpressure: during frame 1, hold y_ready=0 for 5 cycles while y_valid is asserted with y_data=7.
  - Required: y_data stays 7, x_ready=0 and no input is consumed during the stall.
  - After release, the next output is 0.
- Back-to-back frames: send frame 1, then x = 1,2,3,4,5,6,7,8,9,10,11,12,13 with continuous x_valid.
  - Required: second frame yields 2,4,6,8,10,12.
  - 13 is dropped, and the next frame starts cleanly at win_cnt=0.
- Reset mid-window: accept 100, assert reset for 1 cycle, then send 4,9.
  - Required: y_valid=0 and x_ready=0 during reset; first output is 9, not 100.
- Parameter variant L=12, P=3: x = -5,-1,-9,0,0,0,2,8,8,-128,-127,-126.
  - Required: y = -1,0,8,-126.
  - No DRAIN is entered, and a following frame starts immediately.
- Random x_valid/y_ready gaps (≥2000 samples): compare against a reference model.
  - Required: no dropped or duplicated outputs, and y_data is stable while y_valid && !y_ready.
